// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame size and odd-parity helper.
// Used by both the host transmitter and the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RTS       = 3'd1,
    REQ       = 3'd2,
    START     = 3'd3,
    DATA      = 3'd4,
    PARITY    = 3'd5,
    STOP      = 3'd6,
    WAIT_IDLE = 3'd7
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Odd parity bit: makes the total count of ones in {parity, data} odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-FF synchroniser, FILTER_LEN-sample deglitch filter
// and a one-cycle falling-edge pulse on the filtered level. Filter idles high.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic ps2c_filt,
  output logic fall
);

  logic [1:0]            sync_reg;
  logic [FILTER_LEN-1:0] hist_reg;
  logic                  filt_reg;
  logic                  filt_next;
  logic                  fall_reg;

  // Bring the asynchronous pad into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], ps2c_in};
  end

  // Sample history of the synchronised line, newest sample in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_reg <= '1;
    else       hist_reg <= {hist_reg[FILTER_LEN-2:0], sync_reg[1]};
  end

  // A new level is accepted only after FILTER_LEN consecutive equal samples.
  always_comb begin
    filt_next = filt_reg;
    if (&hist_reg)       filt_next = 1'b1;
    else if (~|hist_reg) filt_next = 1'b0;
  end

  // Filtered level and its 1->0 transition pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_reg <= 1'b1;
      fall_reg <= 1'b0;
    end else begin
      filt_reg <= filt_next;
      fall_reg <= filt_reg & ~filt_next;
    end
  end

  assign ps2c_filt = filt_reg;
  assign fall      = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift-out on device
// clock falls, ACK check. Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drv_low,
  output logic       ps2d_drv_low,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_state_t                  state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [PS2_FRAME_BITS-3:0]   shift_reg, shift_next;  // {parity, data}
  logic [2:0]                  n_reg, n_next;
  logic                        dd_reg, dd_next;         // data-line pull-down
  logic                        err_reg, err_next;
  logic [1:0]                  ps2d_sync_reg;
  logic                        ps2c_filt;
  logic                        fall;
  logic                        c_drv;
  logic                        done;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .ps2c_filt(ps2c_filt),
    .fall     (fall)
  );

  // Data line only needs synchronising; it is sampled on filtered clock falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps2d_sync_reg <= 2'b11;
    else       ps2d_sync_reg <= {ps2d_sync_reg[0], ps2d_in};
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            timeout;

  // Watchdog: counts every cycle spent outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wd_reg <= '0;
    else if (state_reg == IDLE) wd_reg <= '0;
    else                        wd_reg <= wd_reg + 1'b1;
  end

  assign timeout = (state_reg != IDLE) && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      n_reg     <= '0;
      dd_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      n_reg     <= n_next;
      dd_reg    <= dd_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic; the data pull-down only changes on a filtered clock fall
  // once the device has taken over the clock.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    n_next     = n_reg;
    dd_next    = dd_reg;
    err_next   = err_reg;
    c_drv      = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wr_ps2) begin
          shift_next = {odd_parity(din), din};
          err_next   = 1'b0;
          cnt_next   = CNT_W'(INHIBIT_CYCLES - 1);
          state_next = RTS;
        end
      end
      RTS: begin
        c_drv = 1'b1;
        if (cnt_reg == '0) begin
          dd_next    = 1'b1;  // start bit
          state_next = REQ;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      REQ: begin
        c_drv      = 1'b1;
        state_next = START;
      end
      START: begin
        if (fall) begin
          dd_next    = ~shift_reg[0];
          shift_next = {1'b0, shift_reg[PS2_FRAME_BITS-3:1]};
          n_next     = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        // Each fall puts the next bit out; the eighth fall here drives parity.
        if (fall) begin
          dd_next    = ~shift_reg[0];
          shift_next = {1'b0, shift_reg[PS2_FRAME_BITS-3:1]};
          if (n_reg == 3'd7) state_next = PARITY;
          else               n_next     = n_reg + 3'd1;
        end
      end
      PARITY: begin
        if (fall) begin
          dd_next    = 1'b0;  // release for the stop bit
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (ps2d_sync_reg[1]) err_next = 1'b1;  // device did not ACK
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (ps2c_filt && ps2d_sync_reg[1]) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Abort overrides everything: release both lines and report the failure.
    if (timeout) begin
      state_next = IDLE;
      dd_next    = 1'b0;
      err_next   = 1'b1;
      c_drv      = 1'b0;
      done       = 1'b1;
    end
`endif
  end

  assign ps2c_drv_low = c_drv;
  assign ps2d_drv_low = dd_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done;
  assign tx_err       = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-drain device model; expected frames are
// queued when a transfer is started and popped when the device has captured it.
module tb_ps2_host_tx;

  localparam int INH      = 40;
  localparam int FLT      = 8;
  localparam int TMO      = 1000;
  localparam int HALF     = 20;
  localparam int WAIT_MAX = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_c_low;
  logic       dev_d_low;
  logic       ps2c_line;
  logic       ps2d_line;
  logic       ps2c_drv_low;
  logic       ps2d_drv_low;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [10:0] exp_q[$];

  // Open-drain bus: either side can pull a line low.
  assign ps2c_line = ~(ps2c_drv_low | dev_c_low);
  assign ps2d_line = ~(ps2d_drv_low | dev_d_low);

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_line),
    .ps2d_in     (ps2d_line),
    .ps2c_drv_low(ps2c_drv_low),
    .ps2d_drv_low(ps2d_drv_low),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err)
  );

  typedef struct {
    logic [10:0] cap;
    int          inh;
    bit          ok;
    bit          seen;
    int          dones;
    logic        err_start;
    logic        err;
    logic        cdrv;
    logic        ddrv;
    logic        busy;
    logic        busy_rewr;
  } obs_t;

  // Start a transfer and queue its expected frame {stop, parity, data, start}.
  task automatic start_tx(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    exp_q.push_back({1'b1, p, d, 1'b0});
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks 11 bits, captures data on
  // rising edges and optionally ACKs on the 11th clock.
  task automatic device_xfer(input bit ack, input int glitch_after, input int rewr_after,
                             input int stop_after, output logic [10:0] cap, output int inh,
                             output logic busy_rewr, output bit ok);
    int t;
    cap = '1; inh = 0; busy_rewr = 1'b0; ok = 1'b1; t = 0;
    while (ps2c_drv_low !== 1'b1 && t < WAIT_MAX) begin @(negedge clk); t++; end
    while (ps2c_drv_low === 1'b1 && t < WAIT_MAX) begin inh++; @(negedge clk); t++; end
    if (t >= WAIT_MAX) begin ok = 1'b0; return; end
    cap[0] = ps2d_line;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF/2) @(negedge clk);
      if (k == 11 && ack) dev_d_low = 1'b1;
      repeat (HALF/2) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == stop_after) return;
      if (k == rewr_after) begin
        din = 8'h55; wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        busy_rewr = tx_busy;
      end
      dev_c_low = 1'b0;
      repeat (2) @(negedge clk);
      if (k <= 10) cap[k] = ps2d_line;
      if (k == 11) begin repeat (HALF) @(negedge clk); dev_d_low = 1'b0; end
      if (k == glitch_after) begin
        repeat (4) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_c_low = 1'b0;
      end
    end
  endtask

  // Runs one full transfer and gathers observations (no comparisons here).
  task automatic do_xfer(input logic [7:0] d, input bit ack, input int glitch_after,
                         input int rewr_after, output obs_t o);
    int base, n;
    logic [10:0] c; int ih; logic br; bit ok;
    base = done_cnt;
    start_tx(d);
    o.err_start = tx_err;
    device_xfer(ack, glitch_after, rewr_after, 0, c, ih, br, ok);
    o.cap = c; o.inh = ih; o.busy_rewr = br; o.ok = ok;
    n = 0;
    while (done_cnt == base && n < 500) begin @(negedge clk); n++; end
    o.seen = (done_cnt != base);
    repeat (5) @(negedge clk);
    o.dones = done_cnt - base;
    o.err   = tx_err;
    o.cdrv  = ps2c_drv_low;
    o.ddrv  = ps2d_drv_low;
    o.busy  = tx_busy;
    $display("xfer din=%h ack=%0d frame=%b inhibit=%0d dones=%0d err=%b", d, ack, o.cap, o.inh, o.dones, o.err);
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_ps2 = 1'b0; din = 8'h00; dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ps2c_drv_low !== 1'b0 || ps2d_drv_low !== 1'b0) begin errors++; $display("FAIL reset_lines: got c=%b d=%b required 0 0", ps2c_drv_low, ps2d_drv_low); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    checks++; if (tx_done_tick !== 1'b0 || tx_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b required 0 0", tx_done_tick, tx_err); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || ps2c_drv_low !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b c=%b required 0 0", tx_busy, ps2c_drv_low); end
    $display("reset done");
  endtask

  task automatic test_frames();
    logic [7:0] bytes [4];
    logic       par   [4];
    obs_t o; logic [10:0] e;
    bytes = '{8'hED, 8'h00, 8'hFF, 8'h01};
    par   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_xfer(bytes[i], 1'b1, 0, 0, o);
      e = exp_q.pop_front();
      checks++; if (!o.ok) begin errors++; $display("FAIL frame_rts_%0d: got no request-to-send required one", i); end
      checks++; if (o.inh != INH + 1) begin errors++; $display("FAIL frame_inhibit_%0d: got %0d cycles required %0d", i, o.inh, INH + 1); end
      checks++; if (o.cap !== e) begin errors++; $display("FAIL frame_bits_%0d: got %b required %b", i, o.cap, e); end
      checks++; if (o.cap[9] !== par[i]) begin errors++; $display("FAIL frame_parity_%0d: got %b required %b", i, o.cap[9], par[i]); end
      checks++; if (!o.seen || o.dones != 1) begin errors++; $display("FAIL frame_done_%0d: got %0d ticks required 1", i, o.dones); end
      checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL frame_err_%0d: got %b required 0", i, o.err); end
      checks++; if (o.cdrv !== 1'b0 || o.ddrv !== 1'b0 || o.busy !== 1'b0) begin errors++; $display("FAIL frame_release_%0d: got c=%b d=%b busy=%b required 0 0 0", i, o.cdrv, o.ddrv, o.busy); end
    end
  endtask

  task automatic test_no_ack();
    obs_t o; logic [10:0] e;
    do_xfer(8'h12, 1'b0, 0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.cap !== e) begin errors++; $display("FAIL noack_bits: got %b required %b", o.cap, e); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL noack_err: got %b required 1", o.err); end
    checks++; if (o.dones != 1) begin errors++; $display("FAIL noack_done: got %0d ticks required 1", o.dones); end
    checks++; if (o.cdrv !== 1'b0 || o.ddrv !== 1'b0 || o.busy !== 1'b0) begin errors++; $display("FAIL noack_release: got c=%b d=%b busy=%b required 0 0 0", o.cdrv, o.ddrv, o.busy); end
    do_xfer(8'h5A, 1'b1, 0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.err_start !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", o.err_start); end
    checks++; if (o.cap !== e || o.err !== 1'b0) begin errors++; $display("FAIL after_noack: got %b err=%b required %b err=0", o.cap, o.err, e); end
  endtask

  task automatic test_rewrite();
    obs_t o; logic [10:0] e;
    do_xfer(8'hA3, 1'b1, 0, 4, o);
    e = exp_q.pop_front();
    checks++; if (o.busy_rewr !== 1'b1) begin errors++; $display("FAIL rewrite_busy: got %b required 1", o.busy_rewr); end
    checks++; if (o.cap !== e) begin errors++; $display("FAIL rewrite_bits: got %b required %b", o.cap, e); end
    checks++; if (o.dones != 1 || o.err !== 1'b0 || o.busy !== 1'b0) begin errors++; $display("FAIL rewrite_end: got dones=%0d err=%b busy=%b required 1 0 0", o.dones, o.err, o.busy); end
  endtask

  task automatic test_glitch();
    obs_t o; logic [10:0] e;
    do_xfer(8'h96, 1'b1, 3, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.cap !== e) begin errors++; $display("FAIL glitch_bits: got %b required %b", o.cap, e); end
    checks++; if (o.dones != 1 || o.err !== 1'b0) begin errors++; $display("FAIL glitch_end: got dones=%0d err=%b required 1 0", o.dones, o.err); end
  endtask

  task automatic test_mid_reset();
    obs_t o; logic [10:0] c, e; int ih; logic br; bit ok;
    start_tx(8'h3C);
    device_xfer(1'b1, 0, 0, 5, c, ih, br, ok);
    checks++; if (tx_busy !== 1'b1 || ps2c_drv_low !== 1'b0) begin errors++; $display("FAIL midreset_pre: got busy=%b c=%b required 1 0", tx_busy, ps2c_drv_low); end
    reset = 1'b1;
    #1;
    checks++; if (ps2c_drv_low !== 1'b0 || ps2d_drv_low !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_async: got c=%b d=%b busy=%b required 0 0 0", ps2c_drv_low, ps2d_drv_low, tx_busy); end
    $display("reset asserted mid-frame din=3c");
    dev_c_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    do_xfer(8'hF4, 1'b1, 0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.cap !== e || o.dones != 1 || o.err !== 1'b0) begin errors++; $display("FAIL after_reset_xfer: got %b dones=%0d err=%b required %b 1 0", o.cap, o.dones, o.err, e); end
  endtask

  task automatic test_timeout();
    int base, n;
    base = done_cnt;
    start_tx(8'h11);
    n = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (done_cnt == base && n < TMO + 100) begin @(negedge clk); n++; end
    checks++; if (n != TMO) begin errors++; $display("FAIL timeout_time: got %0d cycles required %0d", n, TMO); end
    checks++; if (done_cnt - base != 1 || tx_err !== 1'b1) begin errors++; $display("FAIL timeout_flags: got dones=%0d err=%b required 1 1", done_cnt - base, tx_err); end
    checks++; if (tx_busy !== 1'b0 || ps2c_drv_low !== 1'b0 || ps2d_drv_low !== 1'b0) begin errors++; $display("FAIL timeout_release: got busy=%b c=%b d=%b required 0 0 0", tx_busy, ps2c_drv_low, ps2d_drv_low); end
    $display("timeout xfer din=11 cycles=%0d err=%b", n, tx_err);
`else
    repeat (TMO + 100) @(negedge clk);
    checks++; if (tx_busy !== 1'b1 || done_cnt != base) begin errors++; $display("FAIL no_watchdog: got busy=%b dones=%0d required 1 0", tx_busy, done_cnt - base); end
    $display("silent device din=11 busy=%b", tx_busy);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL no_watchdog_reset: got busy=%b required 0", tx_busy); end
`endif
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_frames();
    test_no_ack();
    test_rewrite();
    test_glitch();
    test_mid_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
